iosc_arb: RTL and testbench
===========================

Name: iosc_arb

Overview:
- Two-port arbiter and sequencer for the single skin bus behind the IO/skin channel.
- Shares the bus between the core instruction-fetch port (IF) and the data-memory port (DM).
- Both ports use a request/done handshake; the skin side uses request/acknowledge.
- Owns arbitration, access-timing, a timeout watchdog and per-port read-data capture.

Parameters:
- DATA_WIDTH, 32, width of addresses and data (matches the DATA_WIDTH macro).
- TIMEOUT, 16, ACCESS cycles allowed without ack before error completion; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_if_req  input  1  fetch request; held high until o_if_done.
- i_if_addr  input  DATA_WIDTH  fetch address (PC).
- o_if_done  output  1  one-cycle fetch completion pulse.
- o_if_err  output  1  fetch timed out; valid with o_if_done.
- o_if_data  output  DATA_WIDTH  last fetched instruction word.
- i_dm_req  input  1  data request; held high until o_dm_done.
- i_dm_we  input  1  1 = write, 0 = read.
- i_dm_addr  input  DATA_WIDTH  data address.
- i_dm_wdata  input  DATA_WIDTH  write data.
- o_dm_done  output  1  one-cycle data completion pulse.
- o_dm_err  output  1  data access timed out; valid with o_dm_done.
- o_dm_rdata  output  DATA_WIDTH  last read data.
- o_skin_req  output  1  skin bus access active.
- o_skin_we  output  1  skin write strobe qualifier.
- o_skin_addr  output  DATA_WIDTH  skin address.
- o_skin_data  output  DATA_WIDTH  skin write data.
- i_skin_ack  input  1  skin access complete.
- i_skin_data  input  DATA_WIDTH  skin read data.
- o_busy  output  1  arbiter not IDLE.
- o_owner_dm  output  1  current or last owner: 1 = DM, 0 = IF.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; timeout counter 0.
  - Last-grant flag = DM, so IF wins the first tie.
  - Asynchronous assertion aborts any access in flight with no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port not granted last (round-robin).
  - On grant: latch owner, addr, we and wdata. IF is always a read (we = 0) with addr = i_if_addr. Go to ACCESS.
- ACCESS:
  - o_skin_req = 1. o_skin_addr, o_skin_we and o_skin_data are driven from the latched values and stay stable.
  - Counter increments every cycle, starting at 0.
  - i_skin_ack = 1: on a read, capture i_skin_data into the owner's read register; go to DONE with err = 0.
  - No ack while counter == TIMEOUT-1 and TIMEOUT != 0: go to DONE with err = 1.
  - Ack in the timeout cycle: ack wins, err = 0.
- DONE:
  - Owner's done = 1 for exactly one cycle; owner's err as determined in ACCESS.
  - o_skin_req = 0.
  - Update the last-grant flag; clear the counter; return to IDLE.
- Latency: request sampled in IDLE at cycle 0, ACCESS at cycle 1, done at cycle 2 when ack arrives in the first ACCESS cycle. Each ack wait cycle adds 1.
- Requester rule: deassert req on the clock edge that samples done = 1. req still high in the following IDLE cycle is a new request.
- Input isolation:
  - Changes on i_*_req, addr or data during ACCESS/DONE are ignored.
  - i_skin_ack outside ACCESS is ignored.
- Read data registers:
  - o_if_data and o_dm_rdata hold their value until the next successful read on that port.
  - Writes and errored reads leave them unchanged.
- o_skin_data is 0 on reads. o_owner_dm updates at grant.
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.

Test Plan:
- IF fetch, i_if_addr=0x100, ack in first ACCESS cycle with i_skin_data=0xDEADBEEF -> cycle 1: o_skin_req=1, o_skin_addr=0x100, o_skin_we=0; cycle 2: o_if_done=1, o_if_data=0xDEADBEEF, o_if_err=0.
- IF and DM requests both held from reset, zero-wait ack -> grants in order IF, DM, IF, DM; each done pulse exactly one cycle wide.
- DM write, addr 0x20, data 0x55, ack delayed 3 cycles -> o_skin_req high 4 cycles with o_skin_we=1 and o_skin_data=0x55; o_dm_done at cycle 5; o_dm_rdata unchanged.
- DM read with no ack, TIMEOUT=16 -> o_skin_req high 16 cycles, then o_dm_done=1 with o_dm_err=1; o_dm_rdata unchanged; next access proceeds normally.
- Ack in the 16th ACCESS cycle -> o_dm_done=1, o_dm_err=0, data captured.
- rst_n low mid-ACCESS -> all outputs 0 immediately, no done pulse; after release, a simultaneous request grants IF first.

Source files
------------

// File: rtl/iosc_arb_if.sv
// Handshake bundle for the IO/skin arbiter.
//   IF port  : i_if_req/i_if_addr in, o_if_done/o_if_err/o_if_data out
//   DM port  : i_dm_req/i_dm_we/i_dm_addr/i_dm_wdata in, o_dm_done/o_dm_err/o_dm_rdata out
//   Skin bus : o_skin_req/o_skin_we/o_skin_addr/o_skin_data out, i_skin_ack/i_skin_data in
//   Status   : o_busy, o_owner_dm out
// slave  = arbiter view, master = environment (core + skin) view.
interface iosc_arb_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  i_if_req;
  logic [DATA_WIDTH-1:0] i_if_addr;
  logic                  o_if_done;
  logic                  o_if_err;
  logic [DATA_WIDTH-1:0] o_if_data;

  logic                  i_dm_req;
  logic                  i_dm_we;
  logic [DATA_WIDTH-1:0] i_dm_addr;
  logic [DATA_WIDTH-1:0] i_dm_wdata;
  logic                  o_dm_done;
  logic                  o_dm_err;
  logic [DATA_WIDTH-1:0] o_dm_rdata;

  logic                  o_skin_req;
  logic                  o_skin_we;
  logic [DATA_WIDTH-1:0] o_skin_addr;
  logic [DATA_WIDTH-1:0] o_skin_data;
  logic                  i_skin_ack;
  logic [DATA_WIDTH-1:0] i_skin_data;

  logic                  o_busy;
  logic                  o_owner_dm;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    input  i_skin_ack, i_skin_data,
    output o_if_done, o_if_err, o_if_data, o_dm_done, o_dm_err, o_dm_rdata,
    output o_skin_req, o_skin_we, o_skin_addr, o_skin_data, o_busy, o_owner_dm
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    output i_skin_ack, i_skin_data,
    input  o_if_done, o_if_err, o_if_data, o_dm_done, o_dm_err, o_dm_rdata,
    input  o_skin_req, o_skin_we, o_skin_addr, o_skin_data, o_busy, o_owner_dm
  );
endinterface

// File: rtl/iosc_arb.sv
// Two-port (instruction fetch / data memory) arbiter and sequencer for the skin bus.
// Round-robin on contention, one access at a time, timeout watchdog, per-port read capture.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : iosc_arb_if.slave carrying both request ports, the skin bus and status
module iosc_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic       clk,
  input logic       rst_n,
  iosc_arb_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  last_dm_q, last_dm_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  grant_dm;
  logic                  timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    last_dm_d  = last_dm_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    cnt_d      = cnt_q;
    grant_dm   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.i_if_req || bus.i_dm_req) begin
          // On a tie the port that did not win last time gets the bus.
          grant_dm   = bus.i_dm_req && (!bus.i_if_req || !last_dm_q);
          owner_dm_d = grant_dm;
          addr_d     = grant_dm ? bus.i_dm_addr : bus.i_if_addr;
          we_d       = grant_dm && bus.i_dm_we;
          wdata_d    = (grant_dm && bus.i_dm_we) ? bus.i_dm_wdata : '0;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.i_skin_ack) begin
          if (!we_q) begin
            if (owner_dm_q) dm_rdata_d = bus.i_skin_data;
            else            if_data_d  = bus.i_skin_data;
          end
          err_d   = 1'b0;
          state_d = StDone;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        last_dm_d = owner_dm_q;
        cnt_d     = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_dm_q <= 1'b0;
      last_dm_q  <= 1'b1;  // IF wins the first tie
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      last_dm_q  <= last_dm_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Every output is decoded from registered state only.
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_owner_dm  = owner_dm_q;
  assign bus.o_skin_req  = (state_q == StAccess);
  assign bus.o_skin_we   = (state_q == StAccess) && we_q;
  assign bus.o_skin_addr = (state_q == StAccess) ? addr_q : '0;
  assign bus.o_skin_data = (state_q == StAccess) ? wdata_q : '0;
  assign bus.o_if_done   = (state_q == StDone) && !owner_dm_q;
  assign bus.o_dm_done   = (state_q == StDone) && owner_dm_q;
  assign bus.o_if_err    = (state_q == StDone) && !owner_dm_q && err_q;
  assign bus.o_dm_err    = (state_q == StDone) && owner_dm_q && err_q;
  assign bus.o_if_data   = if_data_q;
  assign bus.o_dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_iosc_arb.sv
// Self-checking bench for iosc_arb: directed vector table, round-robin and reset
// sequences, then randomized transactions scored against a transaction-level model.
module tb_iosc_arb;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iosc_arb_if #(.DATA_WIDTH(32)) bus ();

  iosc_arb #(.DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit          rq_if;
    bit          rq_dm;
    bit          we;
    logic [31:0] if_addr;
    logic [31:0] dm_addr;
    logic [31:0] wdata;
    int          delay;       // ACCESS wait cycles before ack; <0 = never
    logic [31:0] sdata;
    int          exp_lat;     // cycles from request sample to done
    bit          exp_err;
    bit          exp_dm;      // expected winner
    logic [31:0] exp_if_data;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model state
  bit          m_last_dm;
  logic [31:0] m_if;
  logic [31:0] m_dm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_dm = 1'b1;
    m_if      = '0;
    m_dm      = '0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, {24'h0, bus.o_busy, bus.o_skin_req, bus.o_skin_we, bus.o_if_done,
                         bus.o_if_err, bus.o_dm_done, bus.o_dm_err, bus.o_owner_dm}, 32'h0);
    chk({tag, "_skin_addr"}, bus.o_skin_addr, 32'h0);
    chk({tag, "_skin_data"}, bus.o_skin_data, 32'h0);
    chk({tag, "_if_data"}, bus.o_if_data, 32'h0);
    chk({tag, "_dm_rdata"}, bus.o_dm_rdata, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.i_if_req   = 1'b0;
    bus.i_dm_req   = 1'b0;
    bus.i_skin_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Runs one transaction starting in an IDLE cycle (called at a negedge).
  task automatic txn(input vec_t v);
    int          acc;
    bit          done;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [31:0] exp_wd;
    exp_addr = v.exp_dm ? v.dm_addr : v.if_addr;
    exp_we   = v.exp_dm && v.we;
    exp_wd   = exp_we ? v.wdata : 32'h0;
    chk("idle_busy", bus.o_busy, 0);
    bus.i_if_req   = v.rq_if;
    bus.i_dm_req   = v.rq_dm;
    bus.i_dm_we    = v.we;
    bus.i_if_addr  = v.if_addr;
    bus.i_dm_addr  = v.dm_addr;
    bus.i_dm_wdata = v.wdata;
    bus.i_skin_ack = 1'b1;       // must be ignored in IDLE
    bus.i_skin_data = $urandom;
    acc  = 0;
    done = 0;
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      @(negedge clk);
      if (bus.o_skin_req) begin
        if (acc == 0) chk("owner_at_grant", bus.o_owner_dm, v.exp_dm);
        chk("skin_addr", bus.o_skin_addr, exp_addr);
        chk("skin_we", bus.o_skin_we, exp_we);
        chk("skin_data", bus.o_skin_data, exp_wd);
        chk("no_done_in_access", bus.o_if_done | bus.o_dm_done, 0);
        // Port inputs must be ignored once the access has been granted.
        bus.i_if_req    = 1'($urandom_range(0, 1));
        bus.i_dm_req    = 1'($urandom_range(0, 1));
        bus.i_dm_we     = 1'($urandom_range(0, 1));
        bus.i_if_addr   = $urandom;
        bus.i_dm_addr   = $urandom;
        bus.i_dm_wdata  = $urandom;
        bus.i_skin_ack  = (v.delay == acc);
        bus.i_skin_data = (v.delay == acc) ? v.sdata : $urandom;
        acc++;
      end else if (bus.o_if_done || bus.o_dm_done) begin
        done = 1;
        chk("latency", cyc, v.exp_lat);
        chk("access_cycles", acc, v.exp_lat - 1);
        chk("if_done", bus.o_if_done, !v.exp_dm);
        chk("dm_done", bus.o_dm_done, v.exp_dm);
        chk("if_err", bus.o_if_err, !v.exp_dm && v.exp_err);
        chk("dm_err", bus.o_dm_err, v.exp_dm && v.exp_err);
        chk("if_data", bus.o_if_data, v.exp_if_data);
        chk("dm_rdata", bus.o_dm_rdata, v.exp_dm_rdata);
        bus.i_if_req   = 1'b0;
        bus.i_dm_req   = 1'b0;
        bus.i_skin_ack = 1'b1;   // must be ignored in DONE
      end
    end
    chk("done_seen", done, 1);
    bus.i_if_req = 1'b0;
    bus.i_dm_req = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", bus.o_if_done | bus.o_dm_done, 0);
    chk("back_to_idle", bus.o_busy, 0);
  endtask

  // Expectations derived from the arbitration/timing rules, then run.
  task automatic model_run(input bit rq_if, input bit rq_dm, input bit we,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input int delay, input logic [31:0] sd);
    vec_t v;
    bit   w_dm;
    bit   acked;
    if (rq_if && rq_dm) w_dm = !m_last_dm;
    else                w_dm = rq_dm;
    acked = (delay >= 0) && (delay < TIMEOUT);
    if (acked && !(w_dm && we)) begin
      if (w_dm) m_dm = sd;
      else      m_if = sd;
    end
    v = '{rq_if, rq_dm, we, ia, da, wd, delay, sd,
          acked ? delay + 2 : TIMEOUT + 1, !acked, w_dm, m_if, m_dm};
    m_last_dm = w_dm;
    txn(v);
  endtask

  vec_t vecs[8];
  bit   rr_q[$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit prev_if, prev_dm;
    bus.i_if_req    = 1'b1;
    bus.i_dm_req    = 1'b1;
    bus.i_dm_we     = 1'b0;
    bus.i_if_addr   = 32'h200;
    bus.i_dm_addr   = 32'h300;
    bus.i_dm_wdata  = 32'h0;
    bus.i_skin_ack  = 1'b1;
    bus.i_skin_data = 32'h1234_0000;
    model_reset();

    // Reset state with requests already pending
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Both ports held, zero-wait ack: IF, DM, IF, DM
    prev_if = 0;
    prev_dm = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk("rr_exclusive", bus.o_if_done & bus.o_dm_done, 0);
      chk("rr_pulse_width", (bus.o_if_done && prev_if) || (bus.o_dm_done && prev_dm), 0);
      if (bus.o_if_done || bus.o_dm_done) begin
        rr_q.push_back(bus.o_dm_done);
        chk("rr_owner", bus.o_owner_dm, bus.o_dm_done);
      end
      prev_if = bus.o_if_done;
      prev_dm = bus.o_dm_done;
    end
    chk("rr_count", rr_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("rr_order", (i < rr_q.size()) ? rr_q[i] : 1'bx, i % 2);

    // Directed vector table from a fresh reset
    apply_reset();
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,  32'h0,  0,  32'hDEADBEEF,
                2,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h20, 32'h55, 3,  32'h99999999,
                5,  1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h40, 32'h0,  1,  32'hCAFEF00D,
                3,  1'b0, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h44, 32'h0,  -1, 32'h0,
                17, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h48, 32'h0,  15, 32'h0BADC0DE,
                17, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0BADC0DE};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h4C, 32'h0,  2,  32'h11112222,
                4,  1'b0, 1'b0, 32'h11112222, 32'h0BADC0DE};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h50, 32'h77, 0,  32'h33334444,
                2,  1'b0, 1'b1, 32'h11112222, 32'h0BADC0DE};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h10C, 32'h0,  32'h0,  -1, 32'h0,
                17, 1'b1, 1'b0, 32'h11112222, 32'h0BADC0DE};
    for (int i = 0; i < 8; i++) txn(vecs[i]);

    // Asynchronous reset in the middle of an ACCESS
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b0;
    bus.i_dm_addr  = 32'h80;
    bus.i_skin_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_access", {bus.o_busy, bus.o_skin_req}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    bus.i_dm_req = 1'b0;
    @(negedge clk);
    chk("no_done_after_abort", bus.o_if_done | bus.o_dm_done, 0);
    rst_n = 1'b1;
    model_reset();
    model_run(1'b1, 1'b1, 1'b0, 32'h400, 32'h404, 32'h0, 0, 32'hA5A5_5A5A);

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      bit rq_if, rq_dm;
      int r, delay;
      rq_if = 1'($urandom_range(0, 1));
      rq_dm = 1'($urandom_range(0, 1));
      if (!rq_if && !rq_dm) rq_if = 1'b1;
      r = int'($urandom_range(0, 9));
      case (r)
        6:       delay = 14;
        7:       delay = 15;
        8:       delay = 16;
        9:       delay = -1;
        default: delay = r;
      endcase
      model_run(rq_if, rq_dm, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                delay, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
